keypad_scanner_fifo: RTL and testbench
======================================

KEYPAD_SCANNER_FIFO -- requirements
Module: keypad_scanner_fifo

Interface
REQ-001 Parameter ROWS, default 4: number of keypad row inputs (2..8).
REQ-002 Parameter COLS, default 3: number of column drive outputs (2..8).
REQ-003 Parameter SETTLE, default 4: cycles each column is driven before its rows are sampled (minimum 3).
REQ-004 Parameter DEBOUNCE, default 3: consecutive identical sweeps required to accept a press or a release (1..15).
REQ-005 Parameter DEPTH, default 4: key-code FIFO entries (power of 2, 2..16).
REQ-006 Derived CW = clog2(ROWS*COLS), LW = clog2(DEPTH)+1.
REQ-007 clock  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 Col  out  COLS  one-hot column drive, active high.
REQ-010 Row  in  ROWS  raw asynchronous row returns, active high.
REQ-011 Code  out  CW  key code at FIFO head, = column*ROWS + row.
REQ-012 Valid  out  1  FIFO non-empty; Code is meaningful.
REQ-013 Ready  in  1  consumer accepts Code when Valid && Ready.
REQ-014 Level  out  LW  current FIFO occupancy.
REQ-015 Overflow  out  1  sticky: a key code was dropped because the FIFO was full.
REQ-016 Clr_ovf  in  1  clears Overflow.

Function
REQ-017 Row shall pass through a 2-flop synchroniser before any use.
REQ-018 Scan counter: Col holds one column for SETTLE cycles, then advances to the next; column COLS-1 wraps to column 0; one sweep = COLS*SETTLE cycles.
REQ-019 The synchronised Row is captured in the last SETTLE cycle of each column into a ROWS*COLS sweep snapshot.
REQ-020 At sweep end: exactly one snapshot bit set -> candidate = that key code; zero bits -> NONE; two or more bits -> NONE (ghost/multi-key rejection).
REQ-021 Debounce FSM states RELEASED and PRESSED; a stable counter counts consecutive sweeps with the same candidate and resets to 1 on a change.
REQ-022 RELEASED -> PRESSED when a code candidate has been stable for DEBOUNCE sweeps; exactly one push of that code occurs on the transition.
REQ-023 PRESSED -> RELEASED only after NONE is stable for DEBOUNCE sweeps; a different single key while PRESSED produces no push until it has been released first.
REQ-024 Holding a key indefinitely shall produce exactly one push (no auto-repeat).
REQ-025 The FIFO is registered; a pushed code appears on Code/Valid the cycle after the push when the FIFO was empty.
REQ-026 Pop occurs on Valid && Ready; Code advances to the next entry in the following cycle.
REQ-027 Push when full without a simultaneous pop: code dropped, Level unchanged, Overflow set.
REQ-028 Simultaneous push and pop when full: both take effect, Level unchanged, no overflow.
REQ-029 Simultaneous push and pop when empty: push takes effect, pop ignored, Level = 1.
REQ-030 Clr_ovf clears Overflow; if an overflow event occurs in the same cycle, Overflow remains 1.
REQ-031 Read/write pointers wrap modulo DEPTH; Level never exceeds DEPTH.

Reset
REQ-032 While reset is low: Col = one-hot column 0, scan counter 0, synchroniser flops and snapshot 0, FSM = RELEASED, stable counter 0, pointers 0, Level 0, Valid 0, Code 0, Overflow 0.
REQ-033 Reset asserted mid-sweep or mid-debounce discards all partial state; a key held through reset release is pushed once, after DEBOUNCE full sweeps.

Structure
REQ-034 FSM state encoding and the key-code width function belong in a shared package, keypad_pkg.
REQ-035 The FIFO shall be a sub-module, key_fifo, parametrised by CW and DEPTH.

Verification (defaults; sweep = 12 cycles)
REQ-036 Hold key at column 1, row 2 for 60 sweeps, then release -> exactly one push with Code = 6; Valid rises within 4 sweeps plus 3 cycles of press start.
REQ-037 Key bouncing (toggling every 5 cycles for 2 sweeps), then stable -> a single push after 3 stable sweeps; no push during the bounce.
REQ-038 Keys at (col 0, row 0) and (col 2, row 3) pressed together -> no push; release (col 2, row 3) -> push Code = 0.
REQ-039 Ready = 0, press and release 5 distinct keys -> Level = 4, Overflow = 1, FIFO holds the first 4 codes in order; Clr_ovf clears Overflow.
REQ-040 FIFO full, push coinciding with Ready = 1 -> Level stays 4, Overflow stays 0.
REQ-041 Reset pulsed low at sweep 2 of a debounce -> all outputs at reset values; push only after 3 full sweeps following reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: debounce state encoding,
// stable-counter width and the key-code width helper.
package keypad_pkg;

  localparam logic ST_RELEASED = 1'b0;
  localparam logic ST_PRESSED  = 1'b1;

  // Wide enough for the largest debounce threshold (15 sweeps).
  localparam int STABLE_W = 4;

  function automatic int code_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Registered key-code FIFO with an occupancy level and a sticky overflow flag.
// The head entry is presented directly from storage, so a code pushed into an
// empty FIFO is visible on code/valid the cycle after the push.
module key_fifo #(
  parameter int CW    = 4,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH) + 1,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [CW-1:0] push_code,
  input  logic          ready,
  input  logic          clr_ovf,
  output logic [CW-1:0] code,
  output logic          valid,
  output logic [LW-1:0] level,
  output logic          overflow
);

  logic [CW-1:0] mem_q [DEPTH];
  logic [CW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, do_pop, do_push, drop;

  // Next-state: a pop frees a slot for a same-cycle push; a pop on empty is ignored.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LW'(DEPTH));
    do_pop   = ready && !empty;
    do_push  = push && (!full || do_pop);
    drop     = push && full && !do_pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    level_d = level_q + LW'(do_push) - LW'(do_pop);
    // A drop in the same cycle as a clear must leave the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO storage, pointers, level and overflow registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  assign code     = mem_q[rd_ptr_q];
  assign valid    = (level_q != '0);
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/keypad_scanner_fifo.sv
// Matrix keypad scanner: drives one column at a time, snapshots the synchronised
// rows once per sweep, debounces single-key candidates and queues one code per
// accepted press into key_fifo.
//
//   state       | meaning
//   ST_RELEASED | no key accepted; waiting for a single key stable DEBOUNCE sweeps
//   ST_PRESSED  | key pushed; waiting for NONE stable DEBOUNCE sweeps
module keypad_scanner_fifo
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 3,
  parameter int DEPTH    = 4,
  localparam int CW      = code_width(ROWS, COLS),
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  output logic [COLS-1:0] Col,
  input  logic [ROWS-1:0] Row,
  output logic [CW-1:0]   Code,
  output logic            Valid,
  input  logic            Ready,
  output logic [LW-1:0]   Level,
  output logic            Overflow,
  input  logic            Clr_ovf
);

  localparam int NK = ROWS * COLS;
  localparam int SW = $clog2(SETTLE);
  localparam int XW = $clog2(COLS);

  logic [ROWS-1:0]     row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [XW-1:0]       col_idx_q, col_idx_d;
  logic [NK-1:0]       snap_q, snap_d;
  logic                state_q, state_d;
  logic [STABLE_W-1:0] stable_q, stable_d;
  logic                prev_key_q, prev_key_d;
  logic [CW-1:0]       prev_code_q, prev_code_d;
  logic                settle_end, sweep_end, cand_key, same, push;
  logic [CW-1:0]       cand_code;
  int                  hits;

  // Column scan, row snapshot and candidate extraction.
  always_comb begin
    row_s1_d   = Row;
    row_s2_d   = row_s1_q;
    settle_end = (settle_q == SW'(SETTLE - 1));
    sweep_end  = settle_end && (col_idx_q == XW'(COLS - 1));
    settle_d   = settle_end ? '0 : settle_q + SW'(1);
    col_idx_d  = col_idx_q;
    if (settle_end) begin
      col_idx_d = (col_idx_q == XW'(COLS - 1)) ? '0 : col_idx_q + XW'(1);
    end
    snap_d = snap_q;
    for (int c = 0; c < COLS; c++) begin
      if (settle_end && (col_idx_q == XW'(c))) begin
        for (int r = 0; r < ROWS; r++) begin
          snap_d[c*ROWS + r] = row_s2_q[r];
        end
      end
    end
    // The candidate includes the column captured on the sweep-end cycle itself.
    hits      = 0;
    cand_code = '0;
    for (int k = 0; k < NK; k++) begin
      if (snap_d[k]) begin
        hits      = hits + 1;
        cand_code = CW'(k);
      end
    end
    cand_key = (hits == 1);
    if (!cand_key) begin
      cand_code = '0;
    end
    same = (cand_key == prev_key_q) && (cand_code == prev_code_q);
  end

  // Debounce: count identical sweeps and step the press/release FSM at sweep end.
  always_comb begin
    stable_d    = stable_q;
    prev_key_d  = prev_key_q;
    prev_code_d = prev_code_q;
    state_d     = state_q;
    push        = 1'b0;
    if (sweep_end) begin
      if (!same) begin
        stable_d = STABLE_W'(1);
      end else if (stable_q != '1) begin
        stable_d = stable_q + STABLE_W'(1);
      end
      prev_key_d  = cand_key;
      prev_code_d = cand_code;
      if (state_q == ST_RELEASED) begin
        if (cand_key && (stable_d >= STABLE_W'(DEBOUNCE))) begin
          state_d = ST_PRESSED;
          push    = 1'b1;
        end
      end else if (!cand_key && (stable_d >= STABLE_W'(DEBOUNCE))) begin
        state_d = ST_RELEASED;
      end
    end
  end

  // Scanner and debounce registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      settle_q    <= '0;
      col_idx_q   <= '0;
      snap_q      <= '0;
      state_q     <= ST_RELEASED;
      stable_q    <= '0;
      prev_key_q  <= 1'b0;
      prev_code_q <= '0;
    end else begin
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      settle_q    <= settle_d;
      col_idx_q   <= col_idx_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      stable_q    <= stable_d;
      prev_key_q  <= prev_key_d;
      prev_code_q <= prev_code_d;
    end
  end

  // One-hot column drive decoded from the column index.
  always_comb begin
    Col = '0;
    for (int c = 0; c < COLS; c++) begin
      Col[c] = (col_idx_q == XW'(c));
    end
  end

  key_fifo #(
    .CW   (CW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_code(cand_code),
    .ready    (Ready),
    .clr_ovf  (Clr_ovf),
    .code     (Code),
    .valid    (Valid),
    .level    (Level),
    .overflow (Overflow)
  );

endmodule

// File: tb/tb_keypad_scanner_fifo.sv
// Directed bench for keypad_scanner_fifo at default parameters (sweep = 12 cycles).
module tb_keypad_scanner_fifo;

  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int CW   = 4;
  localparam int LW   = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [COLS-1:0] Col;
  logic [ROWS-1:0] Row;
  logic [CW-1:0]   Code;
  logic            Valid;
  logic            Ready = 1'b0;
  logic [LW-1:0]   Level;
  logic            Overflow;
  logic            Clr_ovf = 1'b0;
  logic [11:0]     keys = '0;
  logic [3:0]      drain_exp [4];
  int              total = 0;
  int              bad = 0;

  keypad_scanner_fifo dut (
    .clock   (clock),
    .reset   (reset),
    .Col     (Col),
    .Row     (Row),
    .Code    (Code),
    .Valid   (Valid),
    .Ready   (Ready),
    .Level   (Level),
    .Overflow(Overflow),
    .Clr_ovf (Clr_ovf)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a pressed key connects its column drive to its row return.
  always_comb begin
    Row = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (keys[c*ROWS + r] && Col[c]) Row[r] = 1'b1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0; keys = '0; Ready = 1'b0; Clr_ovf = 1'b0;
    cycles(3);
    reset = 1'b1;
  endtask

  task automatic press_release(input int code);
    keys = '0; keys[code] = 1'b1;
    cycles(60);
    keys = '0;
    cycles(60);
  endtask

  task automatic pop_one();
    Ready = 1'b1; cycles(1); Ready = 1'b0;
  endtask

  task automatic align_sweep();
    int n;
    n = 0;
    while (Col !== 3'b100 && n < 40) begin cycles(1); n++; end
    while (Col !== 3'b001 && n < 80) begin cycles(1); n++; end
    total++; if (Col !== 3'b001) begin bad++; $display("FAIL align_sweep col=%b exp=001", Col); end
  endtask

  task automatic test_reset();
    reset = 1'b0; keys = '0; Ready = 1'b0; Clr_ovf = 1'b0;
    cycles(2);
    total++; if (Col !== 3'b001) begin bad++; $display("FAIL reset_col got=%b exp=001", Col); end
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", Valid); end
    total++; if (Code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", Code); end
    total++; if (Level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", Level); end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", Overflow); end
    reset = 1'b1;
    cycles(5);
    total++; if (Col !== 3'b010) begin bad++; $display("FAIL scan_col1 got=%b exp=010", Col); end
  endtask

  task automatic test_single_key();
    bit found;
    do_reset();
    cycles(29);
    keys[6] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 51 && !found; i++) begin
      cycles(1);
      if (Valid === 1'b1) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL single_valid_latency got=0 exp=1"); end
    total++; if (Code !== 4'd6) begin bad++; $display("FAIL single_code got=%0d exp=6", Code); end
    cycles(700);
    total++; if (Level !== 3'd1) begin bad++; $display("FAIL single_hold_level got=%0d exp=1", Level); end
    keys = '0;
    cycles(60);
    total++; if (Level !== 3'd1) begin bad++; $display("FAIL single_release_level got=%0d exp=1", Level); end
    total++; if (Code !== 4'd6) begin bad++; $display("FAIL single_release_code got=%0d exp=6", Code); end
    pop_one();
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b exp=0", Valid); end
    keys[6] = 1'b1;
    cycles(60);
    total++; if (Level !== 3'd1) begin bad++; $display("FAIL switch_first_level got=%0d exp=1", Level); end
    keys = 12'h080;
    cycles(60);
    total++; if (Level !== 3'd1) begin bad++; $display("FAIL switch_second_level got=%0d exp=1", Level); end
    keys = '0;
    cycles(60);
    total++; if (Level !== 3'd1) begin bad++; $display("FAIL switch_release_level got=%0d exp=1", Level); end
    pop_one();
  endtask

  task automatic test_bounce();
    do_reset();
    cycles(26);
    for (int i = 0; i < 24; i++) begin
      if (i % 5 == 0) keys[4] = ~keys[4];
      cycles(1);
    end
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL bounce_no_push got=%b exp=0", Valid); end
    cycles(33);
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL bounce_early got=%b exp=0", Valid); end
    cycles(1);
    total++; if (Valid !== 1'b1) begin bad++; $display("FAIL bounce_push got=%b exp=1", Valid); end
    total++; if (Code !== 4'd4) begin bad++; $display("FAIL bounce_code got=%0d exp=4", Code); end
    cycles(60);
    keys = '0;
    cycles(60);
    total++; if (Level !== 3'd1) begin bad++; $display("FAIL bounce_level got=%0d exp=1", Level); end
  endtask

  task automatic test_multikey();
    do_reset();
    keys[0] = 1'b1; keys[11] = 1'b1;
    cycles(72);
    total++; if (Level !== 3'd0) begin bad++; $display("FAIL ghost_level got=%0d exp=0", Level); end
    keys[11] = 1'b0;
    cycles(60);
    total++; if (Level !== 3'd1) begin bad++; $display("FAIL ghost_release_level got=%0d exp=1", Level); end
    total++; if (Code !== 4'd0) begin bad++; $display("FAIL ghost_release_code got=%0d exp=0", Code); end
    keys = '0;
    cycles(60);
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_release(9);
    total++; if (Code !== 4'd9) begin bad++; $display("FAIL midrst_pre_code got=%0d exp=9", Code); end
    keys[6] = 1'b1;
    cycles(18);
    reset = 1'b0;
    cycles(2);
    total++; if (Col !== 3'b001) begin bad++; $display("FAIL midrst_col got=%b exp=001", Col); end
    total++; if (Level !== 3'd0) begin bad++; $display("FAIL midrst_level got=%0d exp=0", Level); end
    total++; if (Code !== 4'd0) begin bad++; $display("FAIL midrst_code got=%0d exp=0", Code); end
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", Valid); end
    reset = 1'b1;
    cycles(35);
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL midrst_early got=%b exp=0", Valid); end
    cycles(1);
    total++; if (Valid !== 1'b1) begin bad++; $display("FAIL midrst_push got=%b exp=1", Valid); end
    total++; if (Code !== 4'd6) begin bad++; $display("FAIL midrst_code6 got=%0d exp=6", Code); end
    keys = '0;
    cycles(60);
  endtask

  task automatic test_overflow();
    do_reset();
    press_release(1);
    press_release(5);
    press_release(9);
    press_release(3);
    total++; if (Level !== 3'd4) begin bad++; $display("FAIL ovf_full_level got=%0d exp=4", Level); end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL ovf_full_flag got=%b exp=0", Overflow); end
    press_release(7);
    total++; if (Level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", Level); end
    total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", Overflow); end
    total++; if (Code !== 4'd1) begin bad++; $display("FAIL ovf_head got=%0d exp=1", Code); end
    Clr_ovf = 1'b1; cycles(1); Clr_ovf = 1'b0;
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", Overflow); end
    align_sweep();
    keys[2] = 1'b1;
    cycles(35);
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr_pre got=%b exp=0", Overflow); end
    Clr_ovf = 1'b1; cycles(1); Clr_ovf = 1'b0;
    total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_clr_collide got=%b exp=1", Overflow); end
    cycles(24);
    keys = '0;
    cycles(60);
    Clr_ovf = 1'b1; cycles(1); Clr_ovf = 1'b0;
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear2 got=%b exp=0", Overflow); end
  endtask

  task automatic test_full_push_pop();
    align_sweep();
    keys[10] = 1'b1;
    cycles(35);
    Ready = 1'b1; cycles(1); Ready = 1'b0;
    total++; if (Level !== 3'd4) begin bad++; $display("FAIL fullpp_level got=%0d exp=4", Level); end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL fullpp_ovf got=%b exp=0", Overflow); end
    total++; if (Code !== 4'd5) begin bad++; $display("FAIL fullpp_head got=%0d exp=5", Code); end
    cycles(24);
    keys = '0;
    cycles(60);
    drain_exp[0] = 4'd5; drain_exp[1] = 4'd9; drain_exp[2] = 4'd3; drain_exp[3] = 4'd10;
    for (int i = 0; i < 4; i++) begin
      total++; if (Code !== drain_exp[i]) begin bad++; $display("FAIL drain_code[%0d] got=%0d exp=%0d", i, Code, drain_exp[i]); end
      pop_one();
    end
    total++; if (Level !== 3'd0) begin bad++; $display("FAIL drain_level got=%0d exp=0", Level); end
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", Valid); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_multikey();
    test_reset_mid();
    test_overflow();
    test_full_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
